mem_read_arbiter: RTL and testbench
===================================

Name: mem_read_arbiter

Overview:
- Shares the single AXI read channel to main memory between the instruction cache (requester 0) and the data cache (requester 1).
- Only one burst is outstanding at a time. Responses are routed back to the owner by an internal owner register, not by RID.
- Read grants are withheld while a data-cache write burst is still awaiting its write response, so a refill never overtakes a flush.
- Sits between the two caches' read-address/read-data channels and the memory-side AXI read interface.

Parameters:
ADDR_WIDTH, `ADDR_WIDTH, byte address width of read requests
DATA_WIDTH, `DATA_WIDTH, read data width
LEN_WIDTH, 4, width of ARLEN; ARLEN is the beat count (1..15 legal)

Ports:
clk  input  1  clock
rst_n  input  1  synchronous reset, active low
req_arvalid  input  2  per-requester read-address valid; bit0 = i-cache, bit1 = d-cache
req_arready  output  2  per-requester read-address ready
req_araddr  input  2*ADDR_WIDTH  per-requester address; [ADDR_WIDTH-1:0] = requester 0
req_arlen  input  2*LEN_WIDTH  per-requester beat count
req_rvalid  output  2  per-requester read-data valid
req_rdata  output  DATA_WIDTH  read data, broadcast to both requesters
req_rlast  output  2  per-requester last beat
mem_arvalid  output  1  memory read-address valid
mem_arready  input  1  memory read-address ready
mem_araddr  output  ADDR_WIDTH  memory read address
mem_arlen  output  LEN_WIDTH  memory beat count
mem_arid  output  4  equals the granted requester index (0 or 1)
mem_rvalid  input  1  memory read-data valid
mem_rready  output  1  memory read-data ready
mem_rdata  input  DATA_WIDTH  memory read data
mem_rlast  input  1  memory last beat
wr_aw_fire  input  1  d-cache AWVALID and AWREADY, both high this cycle
wr_b_fire  input  1  d-cache BVALID and BREADY, both high this cycle
burst_err  output  1  sticky error flag

Behaviour:
- One clock; reset is synchronous and active-low (rst_n sampled on posedge clk).
- Reset state:
  - state = IDLE, owner = 0, last_grant = 0 (the d-cache wins the first contention), beat_cnt = 0, wr_pending = 0, burst_err = 0.
  - All valid and ready outputs are 0. mem_araddr, mem_arlen and mem_arid are 0.
- Reset mid-burst: the arbiter returns to IDLE. Subsequent memory beats are not forwarded. burst_err clears.
- wr_pending is a 2-bit counter:
  - Increments on wr_aw_fire; decrements on wr_b_fire.
  - Both in the same cycle: no change.
  - Increment at 3 or decrement at 0: counter holds and burst_err is set.
- State IDLE:
  - All outputs are inactive.
  - If wr_pending == 0 and any req_arvalid bit is set, grant a requester, register it in owner, and go to ADDR.
  - Single requester: grant it.
  - Both requesters: grant ~last_grant (round-robin).
  - If wr_pending != 0, stay in IDLE regardless of requests.
  - A wr_aw_fire in the same cycle as a grant decision does not block that grant. Blocking uses the registered counter only.
- State ADDR:
  - mem_arvalid = 1. mem_araddr and mem_arlen are muxed combinationally from owner. mem_arid = owner.
  - req_arready[owner] = mem_arready; the other bit is 0.
  - Requesters hold address and length stable until ready.
  - On mem_arready: latch len_r = req_arlen[owner], clear beat_cnt, go to DATA.
  - len_r == 0 sets burst_err; that burst then ends on mem_rlast.
- State DATA:
  - mem_rready = 1. req_rdata = mem_rdata. req_rvalid[owner] = mem_rvalid; the other bit is 0.
  - beat_cnt increments on each mem_rvalid.
  - Final beat is the beat where beat_cnt + 1 == len_r, or where mem_rlast = 1, whichever comes first. It asserts req_rlast[owner].
  - mem_rlast and the count must agree. A mismatch sets burst_err, and the burst still ends at the first terminating beat.
  - On the final beat: last_grant = owner, go to IDLE.
  - A new grant is decided in the following IDLE cycle, so there is a minimum 1 bubble cycle between bursts.
- Latency: request seen in IDLE, then mem_arvalid high the next cycle. Read data passes through combinationally (0 cycles).
- Non-owner requests stay pending (req_arready = 0) and are never dropped.

Test Plan:
- Reset, then req_arvalid = 2'b01, addr 0x100, len 4, memory returns 4 beats A..D with rlast on D → mem_araddr = 0x100, mem_arid = 0; req_rvalid[0] is high for 4 beats carrying A..D; req_rlast[0] is high on D; req_rvalid[1] stays 0.
- Both requesters valid from reset (i: 0x200, d: 0x300), len 4 → d (0x300, arid 1) is served first, then i (0x200); with both still requesting, grants alternate 1,0,1,0.
- wr_aw_fire pulse, then req_arvalid = 2'b01 → mem_arvalid stays 0 until wr_b_fire; it rises in the cycle after the IDLE cycle that sees wr_pending == 0.
- Grant d with len 4, mem_arready held 0 for 3 cycles → mem_arvalid and mem_araddr stay stable; req_arready[1] = 0 until mem_arready = 1.
- mem_rlast on beat 2 with len 4 → the burst ends at beat 2, req_rlast is high on beat 2, burst_err = 1 and stays set until rst_n = 0.
- Assert rst_n = 0 after the 2nd beat of a burst → all outputs 0 the next cycle; a 3rd memory beat produces no req_rvalid; after release, a new request is granted normally.

Source files
------------

// File: rtl/mem_read_arbiter.sv
// Shares one AXI read channel between i-cache (0) and d-cache (1), one burst at a time, owner-routed.
// Address goes out the cycle after an IDLE grant; read data passes through combinationally; grants wait on open d-cache writes.
module mem_read_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [1:0]              req_arvalid,
    output logic [1:0]              req_arready,
    input  logic [2*ADDR_WIDTH-1:0] req_araddr,
    input  logic [2*LEN_WIDTH-1:0]  req_arlen,
    output logic [1:0]              req_rvalid,
    output logic [DATA_WIDTH-1:0]   req_rdata,
    output logic [1:0]              req_rlast,
    output logic                    mem_arvalid,
    input  logic                    mem_arready,
    output logic [ADDR_WIDTH-1:0]   mem_araddr,
    output logic [LEN_WIDTH-1:0]    mem_arlen,
    output logic [3:0]              mem_arid,
    input  logic                    mem_rvalid,
    output logic                    mem_rready,
    input  logic [DATA_WIDTH-1:0]   mem_rdata,
    input  logic                    mem_rlast,
    input  logic                    wr_aw_fire,
    input  logic                    wr_b_fire,
    output logic                    burst_err
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    localparam logic [LEN_WIDTH-1:0] LEN_ONE = 1;
    localparam logic [LEN_WIDTH:0]   EXT_ONE = 1;

    state_t                state;
    state_t                state_nxt;
    logic                  owner;
    logic                  last_grant;
    logic                  grant_idx;
    logic [LEN_WIDTH-1:0]  len_r;
    logic [LEN_WIDTH-1:0]  beat_cnt;
    logic [1:0]            wr_pending;
    logic [ADDR_WIDTH-1:0] owner_addr;
    logic [LEN_WIDTH-1:0]  owner_len;
    logic [LEN_WIDTH:0]    cnt_next;
    logic                  grant_go;
    logic                  ar_fire;
    logic                  beat_fire;
    logic                  cnt_done;
    logic                  final_beat;
    logic                  wr_err;
    logic                  len_err;
    logic                  last_err;

    assign owner_addr = owner ? req_araddr[2*ADDR_WIDTH-1:ADDR_WIDTH] : req_araddr[ADDR_WIDTH-1:0];
    assign owner_len  = owner ? req_arlen[2*LEN_WIDTH-1:LEN_WIDTH]    : req_arlen[LEN_WIDTH-1:0];

    // Blocking looks only at the registered write count, so a same-cycle AW does not stop a grant.
    assign grant_go  = (state == IDLE) && (wr_pending == 2'd0) && (|req_arvalid);
    assign grant_idx = (&req_arvalid) ? ~last_grant : req_arvalid[1];
    assign ar_fire   = (state == ADDR) && mem_arready;
    assign beat_fire = (state == DATA) && mem_rvalid;

    // Extra bit keeps a zero-length burst from ever matching the count, so it runs to mem_rlast.
    assign cnt_next   = {1'b0, beat_cnt} + EXT_ONE;
    assign cnt_done   = (cnt_next == {1'b0, len_r});
    assign final_beat = beat_fire && (cnt_done || mem_rlast);
    assign last_err   = beat_fire && (cnt_done != mem_rlast);
    assign len_err    = ar_fire && (owner_len == '0);
    assign wr_err     = (wr_aw_fire && !wr_b_fire && (wr_pending == 2'd3)) ||
                        (wr_b_fire && !wr_aw_fire && (wr_pending == 2'd0));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant_go)    state_nxt = ADDR;
            ADDR:    if (mem_arready) state_nxt = DATA;
            DATA:    if (final_beat)  state_nxt = IDLE;
            default:                  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_arready = 2'b00;
        req_rvalid  = 2'b00;
        req_rlast   = 2'b00;
        req_rdata   = '0;
        mem_arvalid = 1'b0;
        mem_araddr  = '0;
        mem_arlen   = '0;
        mem_arid    = 4'd0;
        mem_rready  = 1'b0;
        case (state)
            ADDR: begin
                mem_arvalid        = 1'b1;
                mem_araddr         = owner_addr;
                mem_arlen          = owner_len;
                mem_arid           = {3'b000, owner};
                req_arready[owner] = mem_arready;
            end
            DATA: begin
                mem_rready        = 1'b1;
                req_rdata         = mem_rdata;
                req_rvalid[owner] = mem_rvalid;
                req_rlast[owner]  = final_beat;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            owner      <= 1'b0;
            last_grant <= 1'b0;
            len_r      <= '0;
            beat_cnt   <= '0;
            wr_pending <= 2'd0;
            burst_err  <= 1'b0;
        end else begin
            if (grant_go) begin
                owner <= grant_idx;
            end
            if (ar_fire) begin
                len_r    <= owner_len;
                beat_cnt <= '0;
            end else if (beat_fire) begin
                beat_cnt <= beat_cnt + LEN_ONE;
            end
            if (final_beat) begin
                last_grant <= owner;
            end
            if (wr_aw_fire && !wr_b_fire && (wr_pending != 2'd3)) begin
                wr_pending <= wr_pending + 2'd1;
            end else if (wr_b_fire && !wr_aw_fire && (wr_pending != 2'd0)) begin
                wr_pending <= wr_pending - 2'd1;
            end
            if (wr_err || len_err || last_err) begin
                burst_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_read_arbiter.sv
// Randomized and directed checks of mem_read_arbiter against a transaction-level arbitration model.
module tb_mem_read_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int LW = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [1:0]      req_arvalid;
    logic [1:0]      req_arready;
    logic [2*AW-1:0] req_araddr;
    logic [2*LW-1:0] req_arlen;
    logic [1:0]      req_rvalid;
    logic [DW-1:0]   req_rdata;
    logic [1:0]      req_rlast;
    logic            mem_arvalid;
    logic            mem_arready;
    logic [AW-1:0]   mem_araddr;
    logic [LW-1:0]   mem_arlen;
    logic [3:0]      mem_arid;
    logic            mem_rvalid;
    logic            mem_rready;
    logic [DW-1:0]   mem_rdata;
    logic            mem_rlast;
    logic            wr_aw_fire;
    logic            wr_b_fire;
    logic            burst_err;

    mem_read_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_arvalid(req_arvalid), .req_arready(req_arready),
        .req_araddr(req_araddr), .req_arlen(req_arlen),
        .req_rvalid(req_rvalid), .req_rdata(req_rdata), .req_rlast(req_rlast),
        .mem_arvalid(mem_arvalid), .mem_arready(mem_arready),
        .mem_araddr(mem_araddr), .mem_arlen(mem_arlen), .mem_arid(mem_arid),
        .mem_rvalid(mem_rvalid), .mem_rready(mem_rready),
        .mem_rdata(mem_rdata), .mem_rlast(mem_rlast),
        .wr_aw_fire(wr_aw_fire), .wr_b_fire(wr_b_fire), .burst_err(burst_err)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] onehot(input int id);
        return (id != 0) ? 2'b10 : 2'b01;
    endfunction

    // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int id, input logic [AW-1:0] addr, input logic [LW-1:0] len);
        req_arvalid[id]        = 1'b1;
        req_araddr[id*AW +: AW] = addr;
        req_arlen[id*LW +: LW]  = len;
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        req_arvalid = '0;
        req_araddr  = '0;
        req_arlen   = '0;
        mem_arready = 1'b0;
        mem_rvalid  = 1'b0;
        mem_rdata   = '0;
        mem_rlast   = 1'b0;
        wr_aw_fire  = 1'b0;
        wr_b_fire   = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;
    endtask

    task automatic check_idle(input string tag);
        #1;
        chk({tag, "_ctl"}, {mem_arvalid, mem_rready, req_arready, req_rvalid, req_rlast, mem_arid, mem_arlen}, 64'd0);
        chk({tag, "_addr"}, {req_rdata, mem_araddr}, 64'd0);
    endtask

    // Waits for the address phase, checks it, holds mem_arready low for gap cycles, then accepts it.
    task automatic accept_ar(input int id, input logic [AW-1:0] addr, input logic [LW-1:0] len,
                             input int gap, input bit drop);
        int k = 0;
        while (!mem_arvalid && k < 60) begin
            cyc();
            #1;
            k++;
        end
        chk("ar_wait", k < 60, 1);
        chk("arid", mem_arid, id);
        chk("araddr", mem_araddr, addr);
        chk("arlen", mem_arlen, len);
        for (int g = 0; g < gap; g++) begin
            chk("ar_hold_rdy", req_arready, 0);
            cyc();
            #1;
            chk("ar_hold_addr", {mem_arvalid, mem_araddr}, {1'b1, addr});
        end
        mem_arready = 1'b1;
        #1;
        chk("req_arready", req_arready, onehot(id));
        cyc();
        mem_arready = 1'b0;
        if (drop) req_arvalid[id] = 1'b0;
    endtask

    task automatic beat(input int id, input bit rl, input bit exp_last);
        logic [DW-1:0] d;
        d          = $urandom;
        mem_rvalid = 1'b1;
        mem_rdata  = d;
        mem_rlast  = rl;
        #1;
        chk("rready", mem_rready, 1);
        chk("rvalid", req_rvalid, onehot(id));
        chk("rdata", req_rdata, d);
        chk("rlast", req_rlast, exp_last ? onehot(id) : 2'b00);
        cyc();
        mem_rvalid = 1'b0;
        mem_rlast  = 1'b0;
    endtask

    task automatic serve(input int id, input logic [AW-1:0] addr, input logic [LW-1:0] len,
                         input int nbeats, input int rlast_at, input int gap, input bit drop);
        accept_ar(id, addr, len, gap, drop);
        for (int b = 0; b < nbeats; b++) beat(id, b == rlast_at - 1, b == nbeats - 1);
        #1;
        chk("bubble", mem_arvalid, 0);
    endtask

    bit             pend [2];
    logic [AW-1:0]  raddr [2];
    logic [LW-1:0]  rlen [2];
    bit             last_model;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Single i-cache burst straight out of reset
        do_reset();
        check_idle("reset");
        chk("reset_err", burst_err, 0);
        set_req(0, 32'h100, 4'd4);
        serve(0, 32'h100, 4'd4, 4, 4, 0, 1);

        // Contention from reset: d-cache first, then strict alternation
        do_reset();
        set_req(0, 32'h200, 4'd4);
        set_req(1, 32'h300, 4'd4);
        for (int i = 0; i < 4; i++)
            serve((i % 2 == 0) ? 1 : 0, (i % 2 == 0) ? 32'h300 : 32'h200, 4'd4, 4, 4, 0, 0);
        req_arvalid = 2'b00;

        // Outstanding write blocks the refill until its response
        do_reset();
        wr_aw_fire = 1'b1;
        cyc();
        wr_aw_fire = 1'b0;
        set_req(0, 32'h400, 4'd2);
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("wr_block", mem_arvalid, 0);
            cyc();
        end
        wr_b_fire = 1'b1;
        #1;
        chk("b_cycle", mem_arvalid, 0);
        cyc();
        wr_b_fire = 1'b0;
        #1;
        chk("b_idle", mem_arvalid, 0);
        cyc();
        #1;
        chk("b_grant", mem_arvalid, 1);
        serve(0, 32'h400, 4'd2, 2, 2, 0, 1);

        // AW in the grant-decision cycle does not block that grant
        cyc();
        set_req(1, 32'h480, 4'd1);
        wr_aw_fire = 1'b1;
        cyc();
        wr_aw_fire = 1'b0;
        #1;
        chk("aw_same_cycle", mem_arvalid, 1);
        serve(1, 32'h480, 4'd1, 1, 1, 0, 1);
        chk("aw_same_err", burst_err, 0);

        // Write counter overflow and underflow
        do_reset();
        wr_aw_fire = 1'b1;
        cyc(); cyc(); cyc();
        #1;
        chk("wr_cnt3_err", burst_err, 0);
        cyc();
        wr_aw_fire = 1'b0;
        #1;
        chk("wr_ovf_err", burst_err, 1);
        do_reset();
        wr_aw_fire = 1'b1;
        wr_b_fire  = 1'b1;
        cyc();
        wr_aw_fire = 1'b0;
        #1;
        chk("wr_both_err", burst_err, 0);
        cyc();
        wr_b_fire = 1'b0;
        #1;
        chk("wr_unf_err", burst_err, 1);

        // Address stalled by memory for 3 cycles
        do_reset();
        set_req(1, 32'h300, 4'd4);
        serve(1, 32'h300, 4'd4, 4, 4, 3, 1);
        chk("stall_err", burst_err, 0);

        // Early mem_rlast ends the burst and sets the sticky error
        do_reset();
        set_req(1, 32'h500, 4'd4);
        serve(1, 32'h500, 4'd4, 2, 2, 0, 1);
        chk("early_last_err", burst_err, 1);
        set_req(0, 32'h600, 4'd3);
        serve(0, 32'h600, 4'd3, 3, 3, 0, 1);
        chk("err_sticky", burst_err, 1);
        do_reset();
        #1;
        chk("err_cleared", burst_err, 0);

        // Zero length runs to mem_rlast and flags an error
        set_req(0, 32'h700, 4'd0);
        serve(0, 32'h700, 4'd0, 3, 3, 0, 1);
        chk("len0_err", burst_err, 1);

        // Reset in the middle of a burst
        do_reset();
        set_req(0, 32'h800, 4'd4);
        accept_ar(0, 32'h800, 4'd4, 0, 1);
        beat(0, 1'b0, 1'b0);
        beat(0, 1'b0, 1'b0);
        rst_n = 1'b0;
        cyc();
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hDEAD_BEEF;
        check_idle("mid_rst");
        chk("mid_rst_err", burst_err, 0);
        cyc();
        rst_n      = 1'b1;
        mem_rvalid = 1'b0;
        set_req(1, 32'h900, 4'd4);
        serve(1, 32'h900, 4'd4, 4, 4, 0, 1);

        // Randomized traffic against the round-robin transaction model
        do_reset();
        last_model = 1'b0;
        pend[0] = 1'b0;
        pend[1] = 1'b0;
        for (int it = 0; it < 40; it++) begin
            int  w;
            bit  flush;
            int  gap;
            for (int r = 0; r < 2; r++) begin
                if (!pend[r] && $urandom_range(0, 2) != 0) begin
                    pend[r]  = 1'b1;
                    raddr[r] = $urandom;
                    rlen[r]  = LW'($urandom_range(1, 15));
                    set_req(r, raddr[r], rlen[r]);
                end
            end
            if (!pend[0] && !pend[1]) begin
                w        = $urandom_range(0, 1);
                pend[w]  = 1'b1;
                raddr[w] = $urandom;
                rlen[w]  = LW'($urandom_range(1, 15));
                set_req(w, raddr[w], rlen[w]);
            end
            w = (pend[0] && pend[1]) ? int'(!last_model) : (pend[1] ? 1 : 0);
            flush = ($urandom_range(0, 3) == 0);
            gap   = $urandom_range(0, 2);
            #1;
            accept_ar(w, raddr[w], rlen[w], gap, 1);
            pend[w]    = 1'b0;
            last_model = (w != 0);
            for (int b = 0; b < int'(rlen[w]); b++) begin
                if ($urandom_range(0, 3) == 0) begin
                    #1;
                    chk("no_beat", req_rvalid, 0);
                    cyc();
                end
                if (flush && b == 0) wr_aw_fire = 1'b1;
                beat(w, b == int'(rlen[w]) - 1, b == int'(rlen[w]) - 1);
                wr_aw_fire = 1'b0;
            end
            #1;
            chk("rand_bubble", mem_arvalid, 0);
            if (flush) begin
                for (int h = 0; h < int'($urandom_range(1, 3)); h++) begin
                    cyc();
                    #1;
                    chk("flush_block", mem_arvalid, 0);
                end
                wr_b_fire = 1'b1;
                cyc();
                wr_b_fire = 1'b0;
            end
        end
        #1;
        chk("rand_err", burst_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
